// File: rtl/hd_bitiso_if.sv
// Handshake bundle for hd_bitiso_unit: input word/opcode channel and result channel.
interface hd_bitiso_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_zero;
    logic             out_err;

    // Producer/consumer side of the unit
    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_zero, out_err
    );

    // The unit itself
    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_zero, out_err
    );
endinterface

// File: rtl/hd_bitiso_unit.sv
// Rightmost-bit manipulation unit: one registered transform per accepted word.
// Optional feature macro HD_BITISO_ENUM_EN adds opcode 5, which streams every
// set bit of the operand lowest first; without it opcode 5 is reserved.
module hd_bitiso_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    hd_bitiso_if.slave bus
);
    localparam int unsigned OP_W = 3;

`ifdef HD_BITISO_ENUM_EN
    localparam logic [OP_W-1:0] OP_ENUM = OP_W'(5);
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, ENUM = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1} state_t;
`endif

    // Lowest set bit of v (v & -v)
    function automatic logic [WIDTH-1:0] low_bit(input logic [WIDTH-1:0] v);
        return v & (WIDTH'(0) - v);
    endfunction

    // v with its lowest set bit cleared (v & (v-1))
    function automatic logic [WIDTH-1:0] clr_low(input logic [WIDTH-1:0] v);
        return v & (v - WIDTH'(1));
    endfunction

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] op_res;
    logic             op_err;
    logic             in_ready_c;
    logic             accept_c;
`ifdef HD_BITISO_ENUM_EN
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_next;
`endif

    // Single-shot transform of the incoming operand; unknown opcodes flag an error
    always_comb begin
        op_res = '0;
        op_err = 1'b0;
        case (bus.in_op)
            OP_W'(0): op_res = ~bus.in_data & (bus.in_data + WIDTH'(1));
            OP_W'(1): op_res = low_bit(bus.in_data);
            OP_W'(2): op_res = clr_low(bus.in_data);
            OP_W'(3): op_res = bus.in_data | (bus.in_data + WIDTH'(1));
            OP_W'(4): op_res = ~bus.in_data & (bus.in_data - WIDTH'(1));
            default:  op_err = 1'b1;
        endcase
    end

`ifdef HD_BITISO_ENUM_EN
    assign in_ready_c = rst_n & (state_q != ENUM) & (~valid_q | bus.out_ready);
`else
    assign in_ready_c = rst_n & (~valid_q | bus.out_ready);
`endif
    assign accept_c = bus.in_valid & in_ready_c;

    // Next-state and next-output decode
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        zero_d  = zero_q;
        err_d   = err_q;
`ifdef HD_BITISO_ENUM_EN
        res_d    = res_q;
        res_next = clr_low(res_q);
`endif
        case (state_q)
            IDLE, HOLD: begin
                if (accept_c) begin
`ifdef HD_BITISO_ENUM_EN
                    if (bus.in_op == OP_ENUM) begin
                        state_d = ENUM;
                        valid_d = 1'b1;
                        res_d   = bus.in_data;
                        data_d  = low_bit(bus.in_data);
                        last_d  = (clr_low(bus.in_data) == '0);
                        zero_d  = (bus.in_data == '0);
                        err_d   = 1'b0;
                    end else
`endif
                    begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                        data_d  = op_res;
                        last_d  = 1'b1;
                        zero_d  = (op_res == '0);
                        err_d   = op_err;
                    end
                end else if ((state_q == HOLD) && bus.out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
`ifdef HD_BITISO_ENUM_EN
            ENUM: begin
                if (bus.out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        res_d  = res_next;
                        data_d = low_bit(res_next);
                        last_d = (clr_low(res_next) == '0);
                        zero_d = (res_next == '0);
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any pending result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef HD_BITISO_ENUM_EN
            res_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
`ifdef HD_BITISO_ENUM_EN
            res_q   <= res_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_last  = last_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_err   = err_q;
endmodule
